// File: rtl/bidmaster_n_if.sv
// Bus interface for the bidmaster_n auction controller.
// Bidder vectors are packed with bidder i at slice i.
interface bidmaster_n_if #(
   parameter int NBIDDERS  = 3,
   parameter int DATAWIDTH = 32
);
   localparam int BIDW = DATAWIDTH / 2;

   logic [NBIDDERS*BIDW-1:0]      bidAmt;
   logic [NBIDDERS-1:0]           bid;
   logic [NBIDDERS-1:0]           retract;
   logic [NBIDDERS-1:0]           ack;
   logic [2*NBIDDERS-1:0]         bidErr;
   logic [NBIDDERS*DATAWIDTH-1:0] balance;
   logic [NBIDDERS-1:0]           win;
   logic [DATAWIDTH-1:0]          C_data;
   logic [3:0]                    C_op;
   logic                          C_start;
   logic                          ready;
   logic [2:0]                    err;
   logic                          roundOver;
   logic [DATAWIDTH-1:0]          maxBid;

   modport master (
      output bidAmt, bid, retract, C_data, C_op, C_start,
      input  ack, bidErr, balance, win, ready, err, roundOver, maxBid
   );

   modport slave (
      input  bidAmt, bid, retract, C_data, C_op, C_start,
      output ack, bidErr, balance, win, ready, err, roundOver, maxBid
   );
endinterface

// File: rtl/bidmaster_n.sv
// bidmaster_n: sealed-bid auction controller for NBIDDERS bidders.
// Control path: UNLOCKED (configuration) -> LOCKED (armed) -> ROUND (bidding).
// Optional feature: define BIDS_RETRACT_EN to let masked bidders retract
// their standing bid during a bid-accepting cycle (the bid charge is kept).
module bidmaster_n #(
   parameter int                   NBIDDERS   = 3,
   parameter int                   DATAWIDTH  = 32,
   parameter logic [DATAWIDTH-1:0] UNLOCK_KEY = 32'hB1D5_2022
) (
   input logic          clk,
   input logic          reset,
   bidmaster_n_if.slave bus
);
   localparam int BIDW = DATAWIDTH / 2;
   localparam int IDXW = $clog2(NBIDDERS);

   localparam logic [3:0] OP_NO_OP       = 4'd0;
   localparam logic [3:0] OP_UNLOCK      = 4'd1;
   localparam logic [3:0] OP_LOCK        = 4'd2;
   localparam logic [3:0] OP_SELECT      = 4'd3;
   localparam logic [3:0] OP_LOADBAL     = 4'd4;
   localparam logic [3:0] OP_SETMASK     = 4'd5;
   localparam logic [3:0] OP_SETTIMER    = 4'd6;
   localparam logic [3:0] OP_SETBIDCHARGE = 4'd7;

   localparam logic [1:0] BE_NONE     = 2'd0;
   localparam logic [1:0] BE_INACTIVE = 2'd1;
   localparam logic [1:0] BE_FUNDS    = 2'd2;
   localparam logic [1:0] BE_INVALID  = 2'd3;

   localparam logic [2:0] ER_NONE    = 3'd0;
   localparam logic [2:0] ER_BADKEY  = 3'd1;
   localparam logic [2:0] ER_ALREADY = 3'd2;
   localparam logic [2:0] ER_CSTART  = 3'd3;
   localparam logic [2:0] ER_INVALID = 3'd4;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_LOCKED   = 2'd1,
      ST_ROUND    = 2'd2
   } state_t;

   state_t                  state_r;
   logic [DATAWIDTH-1:0]    balance_r [NBIDDERS];
   logic [BIDW-1:0]         lastbid_r [NBIDDERS];
   logic [NBIDDERS-1:0]     mask_r;
   logic [DATAWIDTH-1:0]    timer_r;
   logic [DATAWIDTH-1:0]    charge_r;
   logic [DATAWIDTH-1:0]    counter_r;
   logic [IDXW-1:0]         index_r;
   logic [NBIDDERS-1:0]     ack_r;
   logic [2*NBIDDERS-1:0]   bid_err_r;
   logic [NBIDDERS-1:0]     win_r;
   logic                    round_over_r;
   logic                    ready_r;
   logic [2:0]              err_r;
   logic [DATAWIDTH-1:0]    max_bid_r;

   logic                    accepting_s;
   logic [DATAWIDTH:0]      avail_s [NBIDDERS];
   logic [DATAWIDTH:0]      need_s  [NBIDDERS];
   logic [BIDW-1:0]         best_bid_s;
   logic [NBIDDERS-1:0]     best_onehot_s;

   // Bids are only taken while a round still has cycles left on its counter.
   assign accepting_s = (state_r == ST_ROUND) && (counter_r != {DATAWIDTH{1'b0}});

   // Funds check operands, one bit wider than the balance so nothing wraps.
   always_comb begin
      for (int i = 0; i < NBIDDERS; i++) begin
         avail_s[i] = {1'b0, balance_r[i]} + {{(DATAWIDTH+1-BIDW){1'b0}}, lastbid_r[i]};
         need_s[i]  = {{(DATAWIDTH+1-BIDW){1'b0}}, bus.bidAmt[i*BIDW +: BIDW]} + {1'b0, charge_r};
      end
   end

   // Winner search: strict greater-than keeps the lowest index on ties and skips zero bids.
   always_comb begin
      best_bid_s    = {BIDW{1'b0}};
      best_onehot_s = {NBIDDERS{1'b0}};
      for (int i = 0; i < NBIDDERS; i++) begin
         if (mask_r[i] && (lastbid_r[i] > best_bid_s)) begin
            best_bid_s    = lastbid_r[i];
            best_onehot_s = {{(NBIDDERS-1){1'b0}}, 1'b1} << i;
         end else begin
            best_bid_s    = best_bid_s;
            best_onehot_s = best_onehot_s;
         end
      end
   end

   // Main FSM: control ops, bidder request servicing and round settlement.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_UNLOCKED;
         for (int i = 0; i < NBIDDERS; i++) begin
            balance_r[i] <= {DATAWIDTH{1'b0}};
            lastbid_r[i] <= {BIDW{1'b0}};
         end
         mask_r       <= {NBIDDERS{1'b0}};
         timer_r      <= {DATAWIDTH{1'b0}};
         charge_r     <= {DATAWIDTH{1'b0}};
         counter_r    <= {DATAWIDTH{1'b0}};
         index_r      <= {IDXW{1'b0}};
         ack_r        <= {NBIDDERS{1'b0}};
         bid_err_r    <= {(2*NBIDDERS){1'b0}};
         win_r        <= {NBIDDERS{1'b0}};
         round_over_r <= 1'b0;
         ready_r      <= 1'b1;
         err_r        <= ER_NONE;
         max_bid_r    <= {DATAWIDTH{1'b0}};
      end else begin
         round_over_r <= 1'b0;

         // Bidder requests: bid has priority over a simultaneous retract.
         for (int i = 0; i < NBIDDERS; i++) begin
            if (bus.bid[i]) begin
               ack_r[i] <= 1'b1;
               if (!mask_r[i]) begin
                  bid_err_r[2*i +: 2] <= BE_INVALID;
               end else if (!accepting_s) begin
                  bid_err_r[2*i +: 2] <= BE_INACTIVE;
               end else if (avail_s[i] >= need_s[i]) begin
                  bid_err_r[2*i +: 2] <= BE_NONE;
                  balance_r[i]        <= DATAWIDTH'(avail_s[i] - need_s[i]);
                  lastbid_r[i]        <= bus.bidAmt[i*BIDW +: BIDW];
               end else begin
                  bid_err_r[2*i +: 2] <= BE_FUNDS;
               end
            end else if (bus.retract[i]) begin
               ack_r[i] <= 1'b1;
`ifdef BIDS_RETRACT_EN
               if (!mask_r[i]) begin
                  bid_err_r[2*i +: 2] <= BE_INVALID;
               end else if (!accepting_s) begin
                  bid_err_r[2*i +: 2] <= BE_INACTIVE;
               end else begin
                  bid_err_r[2*i +: 2] <= BE_NONE;
                  balance_r[i]        <= avail_s[i][DATAWIDTH-1:0];
                  lastbid_r[i]        <= {BIDW{1'b0}};
               end
`else
               bid_err_r[2*i +: 2] <= BE_INVALID;
`endif
            end else begin
               ack_r[i] <= 1'b0;
            end
         end

         case (state_r)
            ST_UNLOCKED: begin
               if (bus.C_op != OP_NO_OP) begin
                  case (bus.C_op)
                     OP_UNLOCK: err_r <= ER_ALREADY;
                     OP_LOCK: begin
                        state_r <= ST_LOCKED;
                        err_r   <= ER_NONE;
                     end
                     OP_SELECT: begin
                        if (bus.C_data < DATAWIDTH'(NBIDDERS)) begin
                           index_r <= bus.C_data[IDXW-1:0];
                           err_r   <= ER_NONE;
                        end else begin
                           err_r   <= ER_INVALID;
                        end
                     end
                     OP_LOADBAL: begin
                        balance_r[index_r] <= bus.C_data;
                        err_r              <= ER_NONE;
                     end
                     OP_SETMASK: begin
                        mask_r <= bus.C_data[NBIDDERS-1:0];
                        err_r  <= ER_NONE;
                     end
                     OP_SETTIMER: begin
                        timer_r <= bus.C_data;
                        err_r   <= ER_NONE;
                     end
                     OP_SETBIDCHARGE: begin
                        charge_r <= bus.C_data;
                        err_r    <= ER_NONE;
                     end
                     default: err_r <= ER_INVALID;
                  endcase
               end else if (bus.C_start) begin
                  err_r <= ER_CSTART;
               end else begin
                  err_r <= err_r;
               end
            end

            ST_LOCKED: begin
               if (bus.C_op == OP_UNLOCK) begin
                  if (bus.C_data == UNLOCK_KEY) begin
                     state_r <= ST_UNLOCKED;
                     err_r   <= ER_NONE;
                  end else begin
                     err_r   <= ER_BADKEY;
                  end
               end else if (bus.C_op != OP_NO_OP) begin
                  err_r <= ER_INVALID;
               end else if (bus.C_start) begin
                  state_r   <= ST_ROUND;
                  ready_r   <= 1'b0;
                  counter_r <= timer_r;
                  win_r     <= {NBIDDERS{1'b0}};
                  max_bid_r <= {DATAWIDTH{1'b0}};
                  err_r     <= ER_NONE;
               end else begin
                  err_r <= err_r;
               end
            end

            ST_ROUND: begin
               if (bus.C_op != OP_NO_OP) begin
                  err_r <= ER_INVALID;
               end else if (bus.C_start) begin
                  err_r <= ER_NONE;
               end else begin
                  err_r <= err_r;
               end

               if (counter_r != {DATAWIDTH{1'b0}}) begin
                  counter_r <= counter_r - {{(DATAWIDTH-1){1'b0}}, 1'b1};
               end else begin
                  // Settlement: refund losers, consume the winner's bid.
                  for (int i = 0; i < NBIDDERS; i++) begin
                     lastbid_r[i] <= {BIDW{1'b0}};
                     if (!best_onehot_s[i]) begin
                        balance_r[i] <= balance_r[i] + {{(DATAWIDTH-BIDW){1'b0}}, lastbid_r[i]};
                     end else begin
                        balance_r[i] <= balance_r[i];
                     end
                  end
                  max_bid_r    <= {{(DATAWIDTH-BIDW){1'b0}}, best_bid_s};
                  win_r        <= best_onehot_s;
                  round_over_r <= 1'b1;
                  state_r      <= ST_LOCKED;
                  ready_r      <= 1'b1;
               end
            end

            default: begin
               state_r <= ST_UNLOCKED;
               ready_r <= 1'b1;
            end
         endcase
      end
   end

   for (genvar g = 0; g < NBIDDERS; g++) begin : g_balance_out
      assign bus.balance[g*DATAWIDTH +: DATAWIDTH] = balance_r[g];
   end

   assign bus.ack       = ack_r;
   assign bus.bidErr    = bid_err_r;
   assign bus.win       = win_r;
   assign bus.ready     = ready_r;
   assign bus.err       = err_r;
   assign bus.roundOver = round_over_r;
   assign bus.maxBid    = max_bid_r;
endmodule

// File: tb/tb_bidmaster_n.sv
// Scoreboard testbench for bidmaster_n: directed scenarios then random traffic,
// predicted by a behavioural auction model and checked by a separate monitor.
module tb_bidmaster_n;
   localparam int          NB  = 3;
   localparam int          DW  = 32;
   localparam int          BW  = DW / 2;
   localparam logic [31:0] KEY = 32'hB1D5_2022;

   localparam logic [3:0] OP_NOP = 4'd0, OP_UNLOCK = 4'd1, OP_LOCK = 4'd2, OP_SELECT = 4'd3;
   localparam logic [3:0] OP_LOADBAL = 4'd4, OP_SETMASK = 4'd5, OP_SETTIMER = 4'd6, OP_SETCHARGE = 4'd7;
   localparam int M_UNLOCKED = 0, M_LOCKED = 1, M_ROUND = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   bidmaster_n_if #(.NBIDDERS(NB), .DATAWIDTH(DW)) bus();
   bidmaster_n #(.NBIDDERS(NB), .DATAWIDTH(DW), .UNLOCK_KEY(KEY)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   typedef struct { int cyc; int idx; logic [1:0] berr; logic [DW-1:0] bal; } ack_item_t;
   typedef struct { int cyc; logic [NB-1:0] win; logic [DW-1:0] maxbid; logic [NB*DW-1:0] bals; } round_item_t;
   typedef struct { int cyc; logic [2:0] err; logic rdy; logic [NB-1:0] win; logic [DW-1:0] maxbid;
                    logic [NB*DW-1:0] bals; } ctrl_item_t;

   ack_item_t   ack_q[$];
   round_item_t round_q[$];
   ctrl_item_t  ctrl_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc_cnt  = 0;

   // reference model state
   int            m_mode;
   longint        m_bal[NB];
   longint        m_last[NB];
   logic [NB-1:0] m_mask;
   longint        m_timer, m_charge, m_left, m_maxbid;
   int            m_index;
   logic [2:0]    m_err;
   logic [NB-1:0] m_win;

   // stimulus for the next clock edge
   logic             s_reset = 1'b1;
   logic [NB-1:0]    s_bid   = '0;
   logic [NB-1:0]    s_ret   = '0;
   logic [NB*BW-1:0] s_amt   = '0;
   logic [3:0]       s_op    = 4'd0;
   logic [DW-1:0]    s_data  = '0;
   logic             s_start = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc_cnt);
      end
   endtask

   function automatic logic [NB*DW-1:0] bals_flat();
      logic [NB*DW-1:0] f;
      for (int i = 0; i < NB; i++) f[i*DW +: DW] = m_bal[i][DW-1:0];
      return f;
   endfunction

   // Behavioural auction model: applies one cycle of stimulus, queues expected responses.
   task automatic model_apply();
      int         nxt;
      int         pre;
      bit         acc;
      bit         got[NB];
      logic [1:0] e[NB];
      longint     amt, best;
      int         best_i;
      nxt = cyc_cnt + 1;
      if (s_reset) begin
         m_mode = M_UNLOCKED;
         for (int i = 0; i < NB; i++) begin m_bal[i] = 0; m_last[i] = 0; end
         m_mask = '0; m_timer = 0; m_charge = 0; m_left = 0; m_index = 0;
         m_err = 3'd0; m_win = '0; m_maxbid = 0;
         ctrl_q.push_back('{nxt, 3'd0, 1'b1, m_win, m_maxbid[DW-1:0], bals_flat()});
         return;
      end
      pre = m_mode;
      acc = (m_mode == M_ROUND) && (m_left > 0);
      for (int i = 0; i < NB; i++) begin
         got[i] = 1'b0;
         e[i]   = 2'd0;
         amt    = longint'(s_amt[i*BW +: BW]);
         if (s_bid[i]) begin
            got[i] = 1'b1;
            if (!m_mask[i]) e[i] = 2'd3;
            else if (!acc) e[i] = 2'd1;
            else if (m_bal[i] + m_last[i] >= amt + m_charge) begin
               m_bal[i]  = m_bal[i] + m_last[i] - amt - m_charge;
               m_last[i] = amt;
            end else e[i] = 2'd2;
         end else if (s_ret[i]) begin
            got[i] = 1'b1;
`ifdef BIDS_RETRACT_EN
            if (!m_mask[i]) e[i] = 2'd3;
            else if (!acc) e[i] = 2'd1;
            else begin
               m_bal[i]  = m_bal[i] + m_last[i];
               m_last[i] = 0;
            end
`else
            e[i] = 2'd3;
`endif
         end
      end
      if (pre == M_UNLOCKED) begin
         if (s_op == OP_NOP) begin
            if (s_start) m_err = 3'd3;
         end else begin
            m_err = 3'd0;
            case (s_op)
               OP_UNLOCK:    m_err = 3'd2;
               OP_LOCK:      m_mode = M_LOCKED;
               OP_SELECT:    if (s_data < NB) m_index = int'(s_data); else m_err = 3'd4;
               OP_LOADBAL:   m_bal[m_index] = longint'(s_data);
               OP_SETMASK:   m_mask = s_data[NB-1:0];
               OP_SETTIMER:  m_timer = longint'(s_data);
               OP_SETCHARGE: m_charge = longint'(s_data);
               default:      m_err = 3'd4;
            endcase
         end
      end else if (pre == M_LOCKED) begin
         if (s_op == OP_UNLOCK) begin
            if (s_data == KEY) begin m_mode = M_UNLOCKED; m_err = 3'd0; end
            else m_err = 3'd1;
         end else if (s_op != OP_NOP) m_err = 3'd4;
         else if (s_start) begin
            m_mode = M_ROUND; m_left = m_timer; m_win = '0; m_maxbid = 0; m_err = 3'd0;
         end
      end else begin
         if (s_op != OP_NOP) m_err = 3'd4;
         else if (s_start) m_err = 3'd0;
         if (m_left > 0) m_left--;
         else begin
            best = 0; best_i = -1;
            for (int i = 0; i < NB; i++)
               if (m_mask[i] && m_last[i] > best) begin best = m_last[i]; best_i = i; end
            for (int i = 0; i < NB; i++) begin
               if (i != best_i) m_bal[i] = m_bal[i] + m_last[i];
               m_last[i] = 0;
            end
            m_win    = '0;
            if (best_i >= 0) m_win[best_i] = 1'b1;
            m_maxbid = best;
            m_mode   = M_LOCKED;
            round_q.push_back('{nxt, m_win, m_maxbid[DW-1:0], bals_flat()});
         end
      end
      for (int i = 0; i < NB; i++)
         if (got[i]) ack_q.push_back('{nxt, i, e[i], m_bal[i][DW-1:0]});
      if (s_op != OP_NOP || s_start)
         ctrl_q.push_back('{nxt, m_err, (m_mode != M_ROUND), m_win, m_maxbid[DW-1:0], bals_flat()});
   endtask

   // Drive one cycle at the falling edge, predict it, and return just after the rising edge.
   task automatic step();
      @(negedge clk);
      reset       = s_reset;
      bus.bid     = s_bid;
      bus.retract = s_ret;
      bus.bidAmt  = s_amt;
      bus.C_op    = s_op;
      bus.C_data  = s_data;
      bus.C_start = s_start;
      model_apply();
      s_reset = 1'b0; s_bid = '0; s_ret = '0; s_op = OP_NOP; s_start = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic ctrl(input logic [3:0] op, input logic [DW-1:0] data);
      s_op = op; s_data = data; step();
   endtask

   task automatic start_round();
      s_start = 1'b1; step();
   endtask

   task automatic bid1(input int i, input int amt);
      s_bid[i] = 1'b1; s_amt[i*BW +: BW] = BW'(amt); step();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   // Monitor: pops expected responses whenever the DUT presents them.
   logic [2:0] last_err;
   bit         err_known = 1'b0;
   initial begin
      ack_item_t   a;
      round_item_t r;
      ctrl_item_t  c;
      forever begin
         @(posedge clk);
         cyc_cnt++;
         #1;
         for (int i = 0; i < NB; i++) begin
            if (ack_q.size() > 0 && ack_q[0].cyc == cyc_cnt && ack_q[0].idx == i) begin
               a = ack_q.pop_front();
               chk("ack", bus.ack[i], 1'b1);
               chk("bidErr", bus.bidErr[2*i +: 2], a.berr);
               chk("ack_balance", bus.balance[i*DW +: DW], a.bal);
            end else begin
               chk("idle_ack", bus.ack[i], 1'b0);
            end
         end
         while (ack_q.size() > 0 && ack_q[0].cyc <= cyc_cnt) begin
            a = ack_q.pop_front();
            chk("missing_ack", bus.ack[a.idx], 1'b1);
         end
         if (round_q.size() > 0 && round_q[0].cyc == cyc_cnt) begin
            r = round_q.pop_front();
            chk("roundOver", bus.roundOver, 1'b1);
            chk("win", bus.win, r.win);
            chk("maxBid", bus.maxBid, r.maxbid);
            chk("settle_ready", bus.ready, 1'b1);
            for (int i = 0; i < NB; i++) chk("settle_balance", bus.balance[i*DW +: DW], r.bals[i*DW +: DW]);
         end else begin
            chk("idle_roundOver", bus.roundOver, 1'b0);
         end
         if (ctrl_q.size() > 0 && ctrl_q[0].cyc == cyc_cnt) begin
            c = ctrl_q.pop_front();
            chk("err", bus.err, c.err);
            chk("ready", bus.ready, c.rdy);
            chk("ctrl_win", bus.win, c.win);
            chk("ctrl_maxBid", bus.maxBid, c.maxbid);
            for (int i = 0; i < NB; i++) chk("ctrl_balance", bus.balance[i*DW +: DW], c.bals[i*DW +: DW]);
            last_err  = c.err;
            err_known = 1'b1;
         end else if (err_known) begin
            chk("err_hold", bus.err, last_err);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r;
      // reset state
      s_reset = 1'b1; step();
      chk("rst_ready", bus.ready, 1'b1);
      chk("rst_err", bus.err, 3'd0);
      chk("rst_win", bus.win, 3'd0);
      chk("rst_maxBid", bus.maxBid, 32'd0);
      chk("rst_balance", bus.balance, 96'd0);

      ctrl(OP_UNLOCK, 32'h1234_5678);
      chk("scn_already_unlocked", bus.err, 3'd2);
      ctrl(OP_LOCK, 32'd0);
      ctrl(OP_UNLOCK, 32'd1);
      chk("scn_badkey", bus.err, 3'd1);
      ctrl(OP_UNLOCK, KEY);
      chk("scn_unlock_ready", bus.ready, 1'b1);

      // three-bidder round
      for (int i = 0; i < NB; i++) begin ctrl(OP_SELECT, DW'(i)); ctrl(OP_LOADBAL, 32'd100); end
      ctrl(OP_SETMASK, 32'd7); ctrl(OP_SETTIMER, 32'd5); ctrl(OP_SETCHARGE, 32'd1); ctrl(OP_LOCK, 32'd0);
      start_round();
      chk("scn_round_ready", bus.ready, 1'b0);
      bid1(0, 40); bid1(1, 60); bid1(2, 60);
      idle(3);
      chk("scn_roundOver", bus.roundOver, 1'b1);
      chk("scn_win", bus.win, 3'b010);
      chk("scn_maxBid", bus.maxBid, 32'd60);
      chk("scn_balances", bus.balance, {32'd99, 32'd39, 32'd99});
      bid1(1, 5);
      chk("scn_after_settle", bus.bidErr[3:2], 2'd1);

      // insufficient funds
      ctrl(OP_UNLOCK, KEY); ctrl(OP_SELECT, 32'd0); ctrl(OP_LOADBAL, 32'd10);
      ctrl(OP_SETCHARGE, 32'd2); ctrl(OP_SETTIMER, 32'd10); ctrl(OP_LOCK, 32'd0);
      start_round();
      bid1(0, 9);
      chk("scn_funds_err", bus.bidErr[1:0], 2'd2);
      chk("scn_funds_bal", bus.balance[31:0], 32'd10);
      bid1(0, 8);
      chk("scn_exact_bal", bus.balance[31:0], 32'd0);
      idle(12);

      // rebid and retract
      ctrl(OP_UNLOCK, KEY); ctrl(OP_SELECT, 32'd0); ctrl(OP_LOADBAL, 32'd100);
      ctrl(OP_SETCHARGE, 32'd0); ctrl(OP_LOCK, 32'd0);
      start_round();
      bid1(0, 30); bid1(0, 50);
      chk("scn_rebid_bal", bus.balance[31:0], 32'd50);
      s_ret[0] = 1'b1; step();
`ifdef BIDS_RETRACT_EN
      chk("scn_retract_bal", bus.balance[31:0], 32'd100);
      chk("scn_retract_err", bus.bidErr[1:0], 2'd0);
`else
      chk("scn_retract_bal", bus.balance[31:0], 32'd50);
      chk("scn_retract_err", bus.bidErr[1:0], 2'd3);
`endif
      idle(12);

      // masked-off bidder, ops during a round, start while unlocked
      ctrl(OP_UNLOCK, KEY); ctrl(OP_SETMASK, 32'd5); ctrl(OP_LOCK, 32'd0);
      start_round();
      bid1(1, 5);
      chk("scn_masked", bus.bidErr[3:2], 2'd3);
      ctrl(OP_UNLOCK, KEY);
      chk("scn_op_in_round", bus.err, 3'd4);
      idle(12);
      ctrl(OP_UNLOCK, KEY);
      start_round();
      chk("scn_start_unlocked", bus.err, 3'd3);

      // reset in the middle of a round
      ctrl(OP_SELECT, 32'd2); ctrl(OP_LOADBAL, 32'd200); ctrl(OP_SETMASK, 32'd7); ctrl(OP_LOCK, 32'd0);
      start_round();
      bid1(2, 70);
      s_reset = 1'b1; step();
      chk("scn_midround_reset", bus.balance, 96'd0);
      idle(12);

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         r = int'($urandom_range(0, 999));
         if (r < 3) s_reset = 1'b1;
         else begin
            if ($urandom_range(0, 99) < 25) begin
               s_op = 4'($urandom_range(1, 8));
               case (s_op)
                  OP_UNLOCK:    s_data = ($urandom_range(0, 1) == 1) ? KEY : $urandom;
                  OP_SELECT:    s_data = DW'($urandom_range(0, NB));
                  OP_LOADBAL:   s_data = DW'($urandom_range(0, 1000));
                  OP_SETMASK:   s_data = DW'($urandom_range(0, 7));
                  OP_SETTIMER:  s_data = DW'($urandom_range(0, 12));
                  OP_SETCHARGE: s_data = DW'($urandom_range(0, 4));
                  default:      s_data = $urandom;
               endcase
            end
            s_start = ($urandom_range(0, 99) < 10);
            for (int i = 0; i < NB; i++) begin
               s_bid[i] = ($urandom_range(0, 99) < 30);
               s_ret[i] = ($urandom_range(0, 99) < 10);
               s_amt[i*BW +: BW] = BW'($urandom_range(0, 150));
            end
         end
         step();
      end

      idle(3);
      chk("ack_queue_drained", ack_q.size(), 0);
      chk("round_queue_drained", round_q.size(), 0);
      chk("ctrl_queue_drained", ctrl_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
